i2c_target: RTL and testbench
=============================

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 The block SHALL have parameter pSlaveAdrs, default 7'h50, which is the 7-bit target address it responds to.
REQ-002 The block SHALL have parameter pSyncStage, default 2, which is the number of synchronizer flip-flops on iScl and iSda (minimum 2).
REQ-003 The block SHALL have port iSysClk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port iSysRst, input, 1 bit: synchronous active-low reset (0 = reset).
REQ-005 The block SHALL have port iScl, input, 1 bit: I2C SCL, asynchronous.
REQ-006 The block SHALL have port iSda, input, 1 bit: I2C SDA, asynchronous.
REQ-007 The block SHALL have port oSdaOe, output, 1 bit: 1 = pull SDA low; 0 = release SDA. The open-drain pad lives outside this block.
REQ-008 The block SHALL have port oRegAdrs, output, 8 bits: register pointer.
REQ-009 The block SHALL have port oRegWd, output, 8 bits: write data.
REQ-010 The block SHALL have port oRegWe, output, 1 bit: one-cycle write strobe.
REQ-011 The block SHALL have port iRegRd, input, 8 bits: read data for oRegAdrs, valid 1 cycle after oRegAdrs changes.
REQ-012 The block SHALL have port oBusy, output, 1 bit: 1 from an address match until STOP, START or NACK.

Function
REQ-013 The block SHALL synchronize iScl and iSda through pSyncStage FFs and derive SCL rise/fall pulses from the synchronized values.
REQ-014 START SHALL be detected as synchronized SDA falling while SCL is high. STOP SHALL be detected as SDA rising while SCL high.
REQ-015 The FSM states SHALL be IDLE, ADRS, ADRS_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK and IGNORE.
REQ-016 On START, from any state including mid-byte, the FSM SHALL go to ADRS, clear the bit counter and clear oSdaOe in the same cycle. This covers repeated START.
REQ-017 On STOP, from any state, the FSM SHALL go to IDLE, and oSdaOe and oBusy SHALL go to 0.
REQ-018 Data bits SHALL be sampled MSB first on SCL rise. oSdaOe SHALL change only on the cycle after an SCL fall.
REQ-019 ADRS: after 8 bits, if the upper 7 bits equal pSlaveAdrs, the FSM SHALL go to ADRS_ACK and set oBusy=1.
REQ-020 ADRS: if the upper 7 bits do not match, or the address is general call 7'h00, the FSM SHALL go to IGNORE and oSdaOe SHALL stay 0.
REQ-021 ACK drive: oSdaOe SHALL be 1 from the SCL fall ending bit 8 until the SCL fall ending bit 9.
REQ-022 After ADRS_ACK with R/W=0, the FSM SHALL go to PTR. The PTR byte SHALL load oRegAdrs, then PTR_ACK SHALL ACK, then the FSM SHALL go to WDATA.
REQ-023 WDATA: after 8 bits, oRegWd SHALL equal the byte and oRegWe SHALL pulse for exactly 1 cycle, 1 cycle after the 8th SCL rise.
REQ-024 After a WDATA write, WDATA_ACK SHALL ACK and oRegAdrs SHALL increment by 1, modulo 256 (8'hFF wraps to 8'h00).
REQ-025 After ADRS_ACK with R/W=1, the block SHALL sample iRegRd into the shift register at the SCL fall ending the ACK. The FSM SHALL then go to RDATA.
REQ-026 RDATA: oSdaOe SHALL equal the inverted current bit, updated after each SCL fall. oSdaOe SHALL be released at the fall ending bit 8.
REQ-027 After RDATA, oRegAdrs SHALL increment (wrapping) and the FSM SHALL go to RDATA_ACK. The master ACK bit SHALL be sampled at the 9th SCL rise.
REQ-028 RDATA_ACK: master ACK (SDA=0) SHALL load iRegRd at the next SCL fall and return to RDATA.
REQ-029 RDATA_ACK: master NACK SHALL go to IGNORE and set oBusy=0.
REQ-030 IGNORE SHALL leave all outputs unchanged and exit only on START or STOP.
REQ-031 oRegAdrs SHALL persist across transactions. Only reset SHALL clear it.
REQ-032 Clock stretching SHALL NOT be supported. SCL is input only.
REQ-033 Correct operation SHALL be guaranteed for SCL high and low phases each of at least pSyncStage+3 iSysClk cycles.

Reset
REQ-034 While iSysRst=0 at a clock edge, the following SHALL be 0: oSdaOe, oRegWe, oBusy, oRegAdrs, oRegWd, the bit counter and the shift register.
REQ-035 While iSysRst=0 at a clock edge, the FSM SHALL be in IDLE and the synchronizers SHALL be preset to 1 (bus idle).
REQ-036 A reset asserted mid-transfer SHALL release SDA on the next edge. After reset, the block SHALL ignore the bus until the next START.

Verification
REQ-037 The bench SHALL drive START, 0xA0 (address write), pointer 0x10, data 0x5A, 0xC3, STOP. Required response: 3 ACKs; oRegWe pulses with oRegAdrs/oRegWd = 0x10/0x5A and 0x11/0xC3; final oRegAdrs = 0x12.
REQ-038 The bench SHALL set pointer 0x20, then repeated START, 0xA1, read 2 bytes (ACK then NACK), STOP, with a model returning adrs^0xFF. Required response: SDA bytes 0xDF, 0xDE; oBusy falls at NACK; oRegAdrs = 0x22.
REQ-039 The bench SHALL drive START, 0xA2 (wrong address), 3 bytes, STOP. Required response: oSdaOe stays 0 throughout; no oRegWe; oBusy stays 0.
REQ-040 The bench SHALL write with pointer 0xFF and 2 data bytes. Required response: writes at 0xFF then 0x00; final oRegAdrs = 0x01.
REQ-041 The bench SHALL issue START mid-way through a data byte (after bit 4). Required response: no oRegWe; FSM in ADRS; a following 0xA0 is ACKed.
REQ-042 The bench SHALL drive iSysRst=0 while the block is driving an ACK. Required response: oSdaOe = 0 on the next edge; oRegAdrs = 0x00; bytes ignored until the next START.

Source files
------------

// File: rtl/i2c_target.sv
// I2C target with an 8-bit register pointer: write sets pointer then streams data,
// read streams from the pointer. SCL and SDA are oversampled on the system clock.
module i2c_target #(
  parameter logic [6:0] pSlaveAdrs = 7'h50,
  parameter int         pSyncStage = 2
) (
  input  logic       iSysClk,
  input  logic       iSysRst,
  input  logic       iScl,
  input  logic       iSda,
  output logic       oSdaOe,
  output logic [7:0] oRegAdrs,
  output logic [7:0] oRegWd,
  output logic       oRegWe,
  input  logic [7:0] iRegRd,
  output logic       oBusy
);

  typedef enum logic [3:0] {
    IDLE, ADRS, ADRS_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_e;

  logic [pSyncStage-1:0] scl_sync_q, sda_sync_q;
  logic                  scl_prev_q, sda_prev_q;
  logic                  scl_s, sda_s;
  logic                  scl_rise, scl_fall, start_det, stop_det;

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] reg_adrs_q, reg_adrs_d;
  logic [7:0] reg_wd_q, reg_wd_d;
  logic       reg_we_q, reg_we_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;

  assign scl_s     = scl_sync_q[pSyncStage-1];
  assign sda_s     = sda_sync_q[pSyncStage-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  // NOTE: every next-state variable gets a default first so no latch can be inferred.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    reg_adrs_d = reg_adrs_q;
    reg_wd_d   = reg_wd_q;
    reg_we_d   = 1'b0;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    rw_d       = rw_q;

    if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = ADRS;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ADRS: if (scl_rise) begin
          shift_d = {shift_q[6:0], sda_s};
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = 4'd0;
            rw_d      = sda_s;
            if (shift_q[6:0] == pSlaveAdrs && pSlaveAdrs != 7'h00) begin
              state_d = ADRS_ACK;
              busy_d  = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        // ACK states: first fall pulls SDA, second fall ends the ACK slot
        ADRS_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else if (rw_q) begin
            state_d   = RDATA;
            shift_d   = iRegRd;
            sda_oe_d  = ~iRegRd[7];
            bit_cnt_d = 4'd0;
          end else begin
            state_d   = PTR;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
          end
        end
        PTR: if (scl_rise) begin
          shift_d = {shift_q[6:0], sda_s};
          if (bit_cnt_q == 4'd7) begin
            reg_adrs_d = {shift_q[6:0], sda_s};
            state_d    = PTR_ACK;
            bit_cnt_d  = 4'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        PTR_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d  = 1'b0;
            state_d   = WDATA;
            bit_cnt_d = 4'd0;
          end
        end
        WDATA: if (scl_rise) begin
          shift_d = {shift_q[6:0], sda_s};
          if (bit_cnt_q == 4'd7) begin
            reg_wd_d  = {shift_q[6:0], sda_s};
            reg_we_d  = 1'b1;
            state_d   = WDATA_ACK;
            bit_cnt_d = 4'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        // Pointer advances after the strobe so the write sees the old address
        WDATA_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d   = 1'b1;
            reg_adrs_d = reg_adrs_q + 8'd1;
          end else begin
            sda_oe_d  = 1'b0;
            state_d   = WDATA;
            bit_cnt_d = 4'd0;
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shift_d   = {shift_q[6:0], 1'b0};
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d   = 1'b0;
              reg_adrs_d = reg_adrs_q + 8'd1;
              state_d    = RDATA_ACK;
              bit_cnt_d  = 4'd0;
            end else begin
              sda_oe_d = ~shift_q[7];
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end else begin
              bit_cnt_d = 4'd1;
            end
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            state_d   = RDATA;
            shift_d   = iRegRd;
            sda_oe_d  = ~iRegRd[7];
            bit_cnt_d = 4'd0;
          end
        end
        IDLE, IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: non-blocking assignments make every register update from the same pre-edge values.
  always_ff @(posedge iSysClk) begin
    if (!iSysRst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'd0;
      reg_adrs_q <= 8'd0;
      reg_wd_q   <= 8'd0;
      reg_we_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[pSyncStage-2:0], iScl};
      sda_sync_q <= {sda_sync_q[pSyncStage-2:0], iSda};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      reg_adrs_q <= reg_adrs_d;
      reg_wd_q   <= reg_wd_d;
      reg_we_q   <= reg_we_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
    end
  end

  assign oSdaOe   = sda_oe_q;
  assign oRegAdrs = reg_adrs_q;
  assign oRegWd   = reg_wd_q;
  assign oRegWe   = reg_we_q;
  assign oBusy    = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bus-level bench for i2c_target: a bit-banged master plus scoreboards for ACKs,
// register writes and read bytes.
`timescale 1ns/1ps
module tb_i2c_target;

  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl_m, sda_m;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] reg_adrs, reg_wd, reg_rd;
  logic       reg_we, busy;

  int checks = 0;
  int errors = 0;

  logic        ack_q[$];
  logic [15:0] wr_q[$];
  logic [7:0]  rd_q[$];
  logic [15:0] exp_wr;
  logic        oe_seen, busy_seen, we_prev;

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~sda_oe;
  assign reg_rd  = reg_adrs ^ 8'hFF;

  i2c_target #(.pSlaveAdrs(7'h50), .pSyncStage(2)) dut (
    .iSysClk (clk),
    .iSysRst (rst_n),
    .iScl    (scl_m),
    .iSda    (sda_bus),
    .oSdaOe  (sda_oe),
    .oRegAdrs(reg_adrs),
    .oRegWd  (reg_wd),
    .oRegWe  (reg_we),
    .iRegRd  (reg_rd),
    .oBusy   (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write-strobe monitor pops the write scoreboard
  always @(negedge clk) begin
    if (sda_oe === 1'b1) oe_seen <= 1'b1;
    if (busy === 1'b1) busy_seen <= 1'b1;
    we_prev <= reg_we;
    if (reg_we === 1'b1) begin
      check("we_width", {31'd0, we_prev}, 32'd0);
      if (wr_q.size() == 0) begin
        check("we_unexpected", {31'd0, reg_we}, 32'd0);
      end else begin
        exp_wr = wr_q.pop_front();
        check("wr_adrs", {24'd0, reg_adrs}, {24'd0, exp_wr[15:8]});
        check("wr_data", {24'd0, reg_wd}, {24'd0, exp_wr[7:0]});
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; hold(H);
    scl_m = 1'b1; hold(H);
    sda_m = 1'b0; hold(H);
    scl_m = 1'b0; hold(2);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; hold(H);
    scl_m = 1'b1; hold(H);
    sda_m = 1'b1; hold(H);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    hold(H);
    scl_m = 1'b1; hold(H);
    scl_m = 1'b0; hold(2);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; hold(H);
    scl_m = 1'b1; hold(H / 2);
    b = sda_bus;  hold(H / 2);
    scl_m = 1'b0; hold(2);
  endtask

  task automatic write_byte(input logic [7:0] d, input logic exp_ack, input string tag);
    logic a;
    ack_q.push_back(exp_ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    read_bit(a);
    check(tag, {31'd0, a}, {31'd0, ack_q.pop_front()});
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic master_ack, input string tag);
    logic [7:0] got;
    logic       b;
    rd_q.push_back(exp);
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      got[i] = b;
    end
    send_bit(!master_ack);
    check(tag, {24'd0, got}, {24'd0, rd_q.pop_front()});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    oe_seen = 1'b0; busy_seen = 1'b0;
    hold(5);
    check("rst_oe",   {31'd0, sda_oe}, 32'd0);
    check("rst_we",   {31'd0, reg_we}, 32'd0);
    check("rst_busy", {31'd0, busy},   32'd0);
    check("rst_adrs", {24'd0, reg_adrs}, 32'd0);
    check("rst_wd",   {24'd0, reg_wd},   32'd0);
    rst_n = 1'b1;
    hold(5);

    // Pointer write then two data bytes
    i2c_start();
    write_byte(8'hA0, 1'b0, "w_ack_adrs");
    check("w_busy", {31'd0, busy}, 32'd1);
    write_byte(8'h10, 1'b0, "w_ack_ptr");
    wr_q.push_back({8'h10, 8'h5A});
    write_byte(8'h5A, 1'b0, "w_ack_d0");
    wr_q.push_back({8'h11, 8'hC3});
    write_byte(8'hC3, 1'b0, "w_ack_d1");
    i2c_stop();
    check("w_busy_stop", {31'd0, busy}, 32'd0);
    check("w_final_adrs", {24'd0, reg_adrs}, 32'h12);

    // Set pointer, repeated START, read two bytes
    i2c_start();
    write_byte(8'hA0, 1'b0, "r_ack_adrs_w");
    write_byte(8'h20, 1'b0, "r_ack_ptr");
    i2c_start();
    write_byte(8'hA1, 1'b0, "r_ack_adrs_r");
    check("r_busy", {31'd0, busy}, 32'd1);
    read_byte(8'hDF, 1'b1, "r_byte0");
    read_byte(8'hDE, 1'b0, "r_byte1");
    check("r_busy_nack", {31'd0, busy}, 32'd0);
    i2c_stop();
    check("r_final_adrs", {24'd0, reg_adrs}, 32'h22);
    check("r_oe_stop", {31'd0, sda_oe}, 32'd0);

    // Wrong address is ignored entirely
    oe_seen = 1'b0; busy_seen = 1'b0;
    i2c_start();
    write_byte(8'hA2, 1'b1, "x_nack_adrs");
    write_byte(8'h10, 1'b1, "x_nack_b0");
    write_byte(8'h55, 1'b1, "x_nack_b1");
    write_byte(8'hAA, 1'b1, "x_nack_b2");
    i2c_stop();
    check("x_oe_seen", {31'd0, oe_seen}, 32'd0);
    check("x_busy_seen", {31'd0, busy_seen}, 32'd0);
    check("x_adrs_kept", {24'd0, reg_adrs}, 32'h22);

    // Pointer wrap from 0xFF
    i2c_start();
    write_byte(8'hA0, 1'b0, "p_ack_adrs");
    write_byte(8'hFF, 1'b0, "p_ack_ptr");
    wr_q.push_back({8'hFF, 8'h11});
    write_byte(8'h11, 1'b0, "p_ack_d0");
    wr_q.push_back({8'h00, 8'h22});
    write_byte(8'h22, 1'b0, "p_ack_d1");
    i2c_stop();
    check("p_final_adrs", {24'd0, reg_adrs}, 32'h01);

    // START in the middle of a data byte
    i2c_start();
    write_byte(8'hA0, 1'b0, "m_ack_adrs");
    write_byte(8'h40, 1'b0, "m_ack_ptr");
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    i2c_start();
    check("m_busy_restart", {31'd0, busy}, 32'd0);
    check("m_oe_restart", {31'd0, sda_oe}, 32'd0);
    write_byte(8'hA0, 1'b0, "m_ack_after_restart");
    write_byte(8'h41, 1'b0, "m_ack_ptr2");
    i2c_stop();
    check("m_final_adrs", {24'd0, reg_adrs}, 32'h41);

    // Reset while the target drives an ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(logic'(8'hA0 >> i));
    sda_m = 1'b1;
    n = 0;
    while (sda_oe !== 1'b1 && n < 4 * H) begin
      hold(1);
      n++;
    end
    check("q_ack_drive", {31'd0, sda_oe}, 32'd1);
    rst_n = 1'b0;
    hold(1);
    check("q_rst_oe", {31'd0, sda_oe}, 32'd0);
    check("q_rst_adrs", {24'd0, reg_adrs}, 32'd0);
    check("q_rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    hold(H);
    scl_m = 1'b1; hold(H);
    scl_m = 1'b0; hold(2);
    oe_seen = 1'b0;
    write_byte(8'hA0, 1'b1, "q_ignored_byte");
    check("q_oe_seen", {31'd0, oe_seen}, 32'd0);
    i2c_start();
    write_byte(8'hA0, 1'b0, "q_ack_adrs");
    write_byte(8'h33, 1'b0, "q_ack_ptr");
    i2c_stop();
    check("q_final_adrs", {24'd0, reg_adrs}, 32'h33);

    hold(4);
    check("wr_q_empty", wr_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
